// File: rtl/gray_arb_pkg.sv
// Shared constants and types for the two-requester Gray converter arbiter.
// Optional grant statistics are enabled with GRAY_ARB_STATS_EN.
package gray_arb_pkg;

  localparam int GRAY_W = 4;
  localparam int CNT_W  = 16;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

  function automatic logic other_req(
    input logic id
  );
    return (id == REQ0) ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/bin2gray_w.sv
// Purely combinational W-bit binary to Gray code converter.
// g[i] = b[i] ^ b[i+1], MSB passes straight through.
module bin2gray_w #(
  parameter int W = 4
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  always_comb begin
    gray        = '0;
    gray[W-1]   = bin[W-1];
    for (int i = 0; i < W - 1; i++) begin
      gray[i] = bin[i] ^ bin[i+1];
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-Gray converter between two
// requesters; GRAY_ARB_STATS_EN adds saturating per-requester grant counters.
module gray_conv_arbiter
  import gray_arb_pkg::*;
#(
  parameter int W = GRAY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_data,
  output logic         req1_ready,
  output logic         out_valid,
  output logic [W-1:0] out_gray,
  output logic         out_id,
  input  logic         out_ready
`ifdef GRAY_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  buf_state_e   state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic [W-1:0] gray_q, gray_d;
  logic         id_q, id_d;
  logic         live_q;

  logic         can_accept;
  logic         grant;
  logic         hs0, hs1, hs;
  logic [W-1:0] conv_in;
  logic [W-1:0] conv_out;

  bin2gray_w #(
    .W (W)
  ) u_conv (
    .bin  (conv_in),
    .gray (conv_out)
  );

  // live_q keeps readies low until the first edge after reset release
  always_comb begin
    can_accept = live_q &&
                 ((state_q == EMPTY) || out_ready);

    grant = REQ0;
    priority case (1'b1)
      (req0_valid && req1_valid):
        grant = other_req(last_grant_q);
      req1_valid:
        grant = REQ1;
      default:
        grant = REQ0;
    endcase

    req0_ready = can_accept && (grant == REQ0);
    req1_ready = can_accept && (grant == REQ1);

    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;
    hs  = hs0 || hs1;

    conv_in = (grant == REQ1) ? req1_data
                              : req0_data;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gray_d       = gray_q;
    id_d         = id_q;

    if (hs) begin
      state_d      = FULL;
      gray_d       = conv_out;
      id_d         = grant;
      last_grant_d = grant;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      last_grant_q <= REQ1;
      gray_q       <= '0;
      id_q         <= REQ0;
      live_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gray_q       <= gray_d;
      id_q         <= id_d;
      live_q       <= 1'b1;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_gray  = gray_q;
  assign out_id    = id_q;

`ifdef GRAY_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (hs0 && (cnt0_q != '1)) begin
      cnt0_d = cnt0_q + CNT_W'(1);
    end
    if (hs1 && (cnt1_q != '1)) begin
      cnt1_d = cnt1_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Randomized self-checking bench for gray_conv_arbiter against a
// behavioural model of the buffer, round-robin rule and Gray mapping.
module tb_gray_conv_arbiter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready;
  logic         out_valid;
  logic [W-1:0] out_gray;
  logic         out_id;
  logic         out_ready;
`ifdef GRAY_ARB_STATS_EN
  logic [15:0]  grant_cnt0, grant_cnt1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  bit       m_full;
  bit       m_last;
  bit       m_live;
  bit [W-1:0] m_gray;
  bit       m_id;
  int       m_cnt0, m_cnt1;

  always #5 clk = ~clk;

  gray_conv_arbiter #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_gray   (out_gray),
    .out_id     (out_id),
    .out_ready  (out_ready)
`ifdef GRAY_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit [W-1:0] to_gray(input bit [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_full = 0;
    m_last = 1;
    m_live = 0;
    m_gray = '0;
    m_id   = 0;
    m_cnt0 = 0;
    m_cnt1 = 0;
  endtask

  // One cycle: drive at negedge, check, then advance model to next edge.
  task automatic cycle(input bit v0, input bit [W-1:0] d0,
                       input bit v1, input bit [W-1:0] d1,
                       input bit ordy);
    bit can, g, e0, e1;
    @(negedge clk);
    req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1;
    out_ready  = ordy;
    #1;
    can = m_live && (!m_full || ordy);
    if (v0 && v1) g = !m_last;
    else          g = v1;
    e0 = can && !g;
    e1 = can && g;
    chk("ready0", req0_ready, e0);
    chk("ready1", req1_ready, e1);
    chk("valid",  out_valid,  m_full);
    if (m_full) begin
      chk("gray", out_gray, m_gray);
      chk("id",   out_id,   m_id);
    end
    if ((v0 && e0) || (v1 && e1)) begin
      m_full = 1;
      m_id   = g;
      m_last = g;
      m_gray = to_gray(g ? d1 : d0);
      if (g) m_cnt1 = (m_cnt1 < 65535) ? m_cnt1 + 1 : 65535;
      else   m_cnt0 = (m_cnt0 < 65535) ? m_cnt0 + 1 : 65535;
    end else if (m_full && ordy) begin
      m_full = 0;
    end
    m_live = 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  int unsigned tbl [17] = '{0,1,3,2,6,7,5,4,
                            12,13,15,14,10,11,9,8,0};
  logic [W-1:0] prev_g;
  logic [W-1:0] held_g;
  logic         held_id;

  initial begin
    req0_valid = 0; req1_valid = 0;
    req0_data  = '0; req1_data = '0;
    out_ready  = 0;
    rst        = 1'b1;
    #2;
    chk("rst_valid",  out_valid,  1'b0);
    chk("rst_gray",   out_gray,   '0);
    chk("rst_id",     out_id,     1'b0);
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);
    do_reset();

    // first cycle after release: readies still low
    cycle(1, 4'b0101, 0, 0, 1);
    cycle(1, 4'b0101, 0, 0, 1);
    @(posedge clk); #1;
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_gray",  out_gray,  4'b0111);
    chk("t1_id",    out_id,    1'b0);

    // fairness with both valid
    cycle(0, 0, 0, 0, 1);
    do_reset();
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      cycle(1, 4'b0011, 1, 4'b1111, 1);
      @(posedge clk); #1;
      chk("alt_id",   out_id,   (i % 2 == 0) ? 1'b0 : 1'b1);
      chk("alt_gray", out_gray, (i % 2 == 0) ? 4'b0010 : 4'b1000);
    end

    // sweep requester 1 with wrap-around
    for (int k = 0; k < 17; k++) begin
      cycle(0, 0, 1, W'(k % 16), 1);
      @(posedge clk); #1;
      chk("sweep", out_gray, tbl[k]);
      if (k > 0)
        chk("sweep_1bit", $countones(out_gray ^ prev_g), 1);
      prev_g = out_gray;
    end

    // stall: buffer full, out_ready low
    cycle(1, 4'b1010, 1, 4'b0110, 0);
    @(posedge clk); #1;
    held_g  = out_gray;
    held_id = out_id;
    for (int i = 0; i < 5; i++) begin
      cycle(1, 4'b1010, 1, 4'b0110, 0);
      chk("stall_gray", out_gray, held_g);
      chk("stall_id",   out_id,   held_id);
    end
    for (int i = 0; i < 4; i++)
      cycle(1, 4'b1010, 1, 4'b0110, 1);

    // async reset mid-transfer
    cycle(1, 4'b1100, 0, 0, 0);
    @(negedge clk); #2;
    chk("pre_rst_valid", out_valid, 1'b1);
    req0_valid = 1; req1_valid = 1;
    rst = 1'b1;
    #1;
    chk("arst_valid",  out_valid,  1'b0);
    chk("arst_gray",   out_gray,   '0);
    chk("arst_ready0", req0_ready, 1'b0);
    chk("arst_ready1", req1_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    cycle(1, 4'b0001, 1, 4'b0010, 1);
    cycle(1, 4'b0001, 1, 4'b0010, 1);
    @(posedge clk); #1;
    chk("post_rst_id", out_id, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 1), W'($urandom),
            $urandom_range(0, 1), W'($urandom),
            $urandom_range(0, 3) != 0);
    end

`ifdef GRAY_ARB_STATS_EN
    chk("cnt0", grant_cnt0, m_cnt0);
    chk("cnt1", grant_cnt1, m_cnt1);
    do_reset();
    chk("cnt0_rst", grant_cnt0, 0);
    req0_valid = 1; req0_data = 4'b0110;
    req1_valid = 0; out_ready = 1;
    repeat (70000) @(posedge clk);
    #1;
    chk("cnt0_sat", grant_cnt0, 16'hFFFF);
    chk("cnt1_idle", grant_cnt1, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
